// File: rtl/clk_div_sequencer.sv
// Run-time reprogrammable clock divider with glitch-free ratio sequencing.
// Define CLK_DIV_SEQ_CNT_EN to add the reconfig_cnt output.
module clk_div_sequencer #(
  parameter int DIV_W         = 8,
  parameter int DEFAULT_DIV   = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             SYS_CLK_IN,
  input  logic             SYS_RST_IN,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             cfg_done,
  output logic             busy,
  output logic [DIV_W-1:0] cur_div,
  output logic             div_clk_out,
`ifdef CLK_DIV_SEQ_CNT_EN
  output logic             div_en_out,
  output logic [7:0]       reconfig_cnt
`else
  output logic             div_en_out
`endif
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {
    SETTLE,
    RUN,
    DRAIN
  } state_t;

  state_t           state, state_nxt;
  logic [SW-1:0]    scnt, scnt_nxt;
  logic [DIV_W-1:0] cnt, cnt_nxt, wrap;
  logic [DIV_W-1:0] div_nxt;
  logic [DIV_W-1:0] pending, pending_nxt;
  logic [DIV_W:0]   half_nxt;
  logic             last, live_nxt;
  logic             clk_nxt, en_nxt;
  logic             done_nxt, err_nxt;

  assign cfg_ready = (state == RUN);
  assign busy      = (state != RUN);

  assign last = (cnt == cur_div - DIV_W'(1));
  assign wrap = last ? '0 : cnt + DIV_W'(1);

  always_comb begin
    state_nxt   = state;
    scnt_nxt    = scnt;
    cnt_nxt     = cnt;
    div_nxt     = cur_div;
    pending_nxt = pending;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    unique case (state)
      SETTLE: begin
        cnt_nxt = '0;
        if (scnt == SW'(SETTLE_CYCLES - 1)) begin
          state_nxt = RUN;
          scnt_nxt  = '0;
          done_nxt  = 1'b1;
        end else begin
          scnt_nxt = scnt + SW'(1);
        end
      end
      RUN: begin
        cnt_nxt = wrap;
        if (cfg_valid) begin
          if (cfg_div < DIV_W'(2)) begin
            err_nxt = 1'b1;
          end else if (cfg_div == cur_div) begin
            done_nxt = 1'b1;
          end else begin
            pending_nxt = cfg_div;
            state_nxt   = DRAIN;
          end
        end
      end
      DRAIN: begin
        cnt_nxt = wrap;
        if (last) begin
          state_nxt = SETTLE;
          div_nxt   = pending;
          scnt_nxt  = '0;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = SETTLE;
    endcase
    // Outputs derive from next-state values so the registers line up with cnt
    live_nxt = (state_nxt == RUN) || (state_nxt == DRAIN);
    half_nxt = ({1'b0, div_nxt} + (DIV_W+1)'(1)) >> 1;
    clk_nxt  = live_nxt && ({1'b0, cnt_nxt} < half_nxt);
    en_nxt   = live_nxt && (cnt_nxt == div_nxt - DIV_W'(1));
  end

  always_ff @(posedge SYS_CLK_IN or posedge SYS_RST_IN) begin
    if (SYS_RST_IN) begin
      state       <= SETTLE;
      scnt        <= '0;
      cnt         <= '0;
      cur_div     <= DIV_W'(DEFAULT_DIV);
      pending     <= DIV_W'(DEFAULT_DIV);
      div_clk_out <= 1'b0;
      div_en_out  <= 1'b0;
      cfg_err     <= 1'b0;
      cfg_done    <= 1'b0;
    end else begin
      state       <= state_nxt;
      scnt        <= scnt_nxt;
      cnt         <= cnt_nxt;
      cur_div     <= div_nxt;
      pending     <= pending_nxt;
      div_clk_out <= clk_nxt;
      div_en_out  <= en_nxt;
      cfg_err     <= err_nxt;
      cfg_done    <= done_nxt;
    end
  end

`ifdef CLK_DIV_SEQ_CNT_EN
  // chg marks a settle that follows a real ratio change, not reset exit
  logic chg;

  always_ff @(posedge SYS_CLK_IN or posedge SYS_RST_IN) begin
    if (SYS_RST_IN) begin
      chg          <= 1'b0;
      reconfig_cnt <= '0;
    end else if (state == DRAIN && state_nxt == SETTLE) begin
      chg <= 1'b1;
    end else if (state == SETTLE && state_nxt == RUN) begin
      chg <= 1'b0;
      if (chg && reconfig_cnt != 8'hFF)
        reconfig_cnt <= reconfig_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_clk_div_sequencer.sv
// Randomized directed bench for clk_div_sequencer with a waveform-queue model.
// Builds with or without CLK_DIV_SEQ_CNT_EN.
module tb_clk_div_sequencer;

  localparam int DW  = 8;
  localparam int DEF = 2;
  localparam int SET = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic [DW-1:0] cfg_div = '0;
  logic          cfg_ready, cfg_err, cfg_done, busy;
  logic [DW-1:0] cur_div;
  logic          div_clk_out, div_en_out;
`ifdef CLK_DIV_SEQ_CNT_EN
  logic [7:0]    reconfig_cnt;
`endif

  clk_div_sequencer #(
    .DIV_W(DW), .DEFAULT_DIV(DEF), .SETTLE_CYCLES(SET)
  ) dut (
    .SYS_CLK_IN (clk),
    .SYS_RST_IN (rst),
    .cfg_valid  (cfg_valid),
    .cfg_div    (cfg_div),
    .cfg_ready  (cfg_ready),
    .cfg_err    (cfg_err),
    .cfg_done   (cfg_done),
    .busy       (busy),
    .cur_div    (cur_div),
    .div_clk_out(div_clk_out),
`ifdef CLK_DIV_SEQ_CNT_EN
    .div_en_out (div_en_out),
    .reconfig_cnt(reconfig_cnt)
`else
    .div_en_out (div_en_out)
`endif
  );

  always #5 clk = ~clk;

  // One expected output cycle
  typedef struct {
    bit clk;
    bit en;
    bit busy;
    bit done;
    bit chg;
    int div;
  } item_t;

  item_t q[$];
  item_t cur;
  bit    m_err;
  int    mod_div;
  int    mcnt;
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic push_item(input bit c, input bit e, input bit b,
                           input int d);
    item_t t;
    t.clk = c; t.en = e; t.busy = b;
    t.done = 0; t.chg = 0; t.div = d;
    q.push_back(t);
  endtask

  // A whole period: ceil(d/2) high cycles, then low, enable on the last
  task automatic push_period(input int d, input bit b, input bit first);
    item_t t;
    for (int i = 0; i < d; i++) begin
      t.clk  = (i < (d + 1) / 2);
      t.en   = (i == d - 1);
      t.busy = b;
      t.done = first && (i == 0);
      t.chg  = 0;
      t.div  = d;
      q.push_back(t);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mod_div = DEF;
    m_err = 0;
    mcnt = 0;
    for (int i = 0; i < SET; i++) push_item(0, 0, 1, DEF);
    push_period(DEF, 0, 1);
    cur = q.pop_front();
  endtask

  task automatic adv(input bit acc, input int d);
    bit nd = 0;
    bit ne = 0;
    item_t t;
    if (acc) begin
      if (d < 2) begin
        ne = 1;
      end else if (d == mod_div) begin
        nd = 1;
      end else begin
        // The period in progress finishes; if it just ended, a full one drains
        if (q.size() == 0) begin
          push_period(mod_div, 1, 0);
        end else begin
          for (int i = 0; i < q.size(); i++) begin
            t = q[i]; t.busy = 1; q[i] = t;
          end
        end
        for (int i = 0; i < SET; i++) push_item(0, 0, 1, d);
        push_period(d, 0, 1);
        t = q[q.size() - d]; t.chg = 1; q[q.size() - d] = t;
        mod_div = d;
      end
    end
    if (q.size() == 0) push_period(mod_div, 0, 0);
    cur = q.pop_front();
    cur.done = cur.done | nd;
    m_err = ne;
    if (cur.done && cur.chg && mcnt < 255) mcnt++;
  endtask

  task automatic tick(output bit acc);
    chk("div_clk", div_clk_out, cur.clk);
    chk("div_en", div_en_out, cur.en);
    chk("busy", busy, cur.busy);
    chk("cfg_ready", cfg_ready, !cur.busy);
    chk("cfg_done", cfg_done, cur.done);
    chk("cfg_err", cfg_err, m_err);
    chk("cur_div", cur_div, cur.div);
`ifdef CLK_DIV_SEQ_CNT_EN
    chk("reconfig_cnt", reconfig_cnt, mcnt);
`endif
    acc = cfg_valid && !cur.busy;
    adv(acc, int'(cfg_div));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) tick(a);
  endtask

  task automatic request(input logic [DW-1:0] d);
    bit acc = 0;
    int n = 0;
    cfg_valid = 1;
    cfg_div = d;
    while (!acc && n < 200) begin
      tick(acc);
      n++;
    end
    cfg_valid = 0;
    chk("handshake", acc, 1);
  endtask

  task automatic check_reset_vals();
    chk("rst_div_clk", div_clk_out, 0);
    chk("rst_div_en", div_en_out, 0);
    chk("rst_busy", busy, 1);
    chk("rst_ready", cfg_ready, 0);
    chk("rst_done", cfg_done, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_cur_div", cur_div, DEF);
`ifdef CLK_DIV_SEQ_CNT_EN
    chk("rst_reconfig_cnt", reconfig_cnt, 0);
`endif
  endtask

  initial begin
    int n;
    bit a;
    @(negedge clk);
    @(negedge clk);
    check_reset_vals();
    rst = 0;
    model_reset();
    idle(10);

    request(4);
    idle(20);
    request(1);
    idle(3);
    request(0);
    idle(5);
    request(4);
    idle(10);
    request(3);
    idle(15);

    for (int k = 0; k < 10; k++) begin
      idle($urandom_range(0, 6));
      request(DW'($urandom_range(0, 12)));
    end
    idle(40);

    // Reset while settling into ratio 7
    request(7);
    n = 0;
    while (!(cur.busy && cur.div == 7) && n < 100) begin
      tick(a);
      n++;
    end
    chk("reach_settle", cur.div, 7);
    #2 rst = 1;
    #1 check_reset_vals();
    @(negedge clk);
    rst = 0;
    model_reset();
    idle(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
